// File: rtl/execute_if.sv
// Instruction, result, store and forwarding bundle between read, execute and write.
// The slave modport is the execute side; the master modport is whatever drives it.
interface execute_if #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
);
    logic                in_valid;
    logic                in_hold;
    logic [WIDTH-1:0]    pc;
    logic [3:0]          operation;
    logic [REG_BITS-1:0] target_register;
    logic [WIDTH-1:0]    left_value;
    logic [WIDTH-1:0]    right_value;
    logic [WIDTH-1:0]    adjustment_value;
    logic                is_writing_memory;
    logic                flush;
    logic                out_valid;
    logic                out_hold;
    logic [WIDTH-1:0]    out_pc;
    logic [WIDTH-1:0]    result;
    logic [REG_BITS-1:0] out_target_register;
    logic                mem_write;
    logic [WIDTH-1:0]    mem_address;
    logic [WIDTH-1:0]    mem_data;
    logic [3:0]          flags;
    logic                fb_valid;
    logic [REG_BITS-1:0] fb_register;
    logic [WIDTH-1:0]    fb_value;

    modport slave (
        input  in_valid, pc, operation, target_register, left_value, right_value,
               adjustment_value, is_writing_memory, flush, out_hold,
        output in_hold, out_valid, out_pc, result, out_target_register, mem_write,
               mem_address, mem_data, flags, fb_valid, fb_register, fb_value
    );

    modport master (
        output in_valid, pc, operation, target_register, left_value, right_value,
               adjustment_value, is_writing_memory, flush, out_hold,
        input  in_hold, out_valid, out_pc, result, out_target_register, mem_write,
               mem_address, mem_data, flags, fb_valid, fb_register, fb_value
    );
endinterface

// File: rtl/execute.sv
// ALU/store stage: 1-cycle ops, WIDTH-iteration shift-add MUL (result at cycle WIDTH+2).
// out_hold freezes all outputs (multiplier keeps iterating); in_hold stalls read while busy or held.
module execute #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic     clock,
    input  logic     reset_n,
    execute_if.slave bus
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, LATCH, MUL, DONE} state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       count;
    logic [WIDTH-1:0]    mcand, mplier, acc;

    logic                out_valid_q, mem_write_q;
    logic [WIDTH-1:0]    out_pc_q, result_q, mem_address_q, mem_data_q;
    logic [REG_BITS-1:0] out_target_q;
    logic [3:0]          flags_q;

    logic                mul_start, busy, complete;
    logic [WIDTH:0]      sum_ext;
    logic [WIDTH-1:0]    diff;
    logic [SW-1:0]       shamt;
    logic [WIDTH-1:0]    alu_res, fin_res;
    logic                alu_c, alu_v, fin_c, fin_v;

    assign mul_start = (state == IDLE) && bus.in_valid && (bus.operation == 4'd8) && !bus.flush;
    assign busy      = (state == LATCH) || (state == MUL) || mul_start;
    assign complete  = !bus.flush && !bus.out_hold &&
                       (((state == IDLE) && bus.in_valid && (bus.operation != 4'd8)) ||
                        (state == DONE));
    assign bus.in_hold = (bus.out_hold || busy) && bus.in_valid && !bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start) state_nxt = LATCH;
            LATCH:   state_nxt = MUL;
            MUL:     if (count == '0) state_nxt = DONE;
            DONE:    if (!bus.out_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    assign sum_ext = {1'b0, bus.left_value} + {1'b0, bus.right_value};
    assign diff    = bus.left_value - bus.right_value;
    assign shamt   = bus.right_value[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.operation)
            4'd0: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (bus.left_value[MSB] == bus.right_value[MSB]) &&
                          (sum_ext[MSB] != bus.left_value[MSB]);
            end
            4'd1: begin
                alu_res = diff;
                alu_c   = bus.left_value < bus.right_value;
                alu_v   = (bus.left_value[MSB] != bus.right_value[MSB]) &&
                          (diff[MSB] != bus.left_value[MSB]);
            end
            4'd2: alu_res = bus.left_value & bus.right_value;
            4'd3: alu_res = bus.left_value | bus.right_value;
            4'd4: alu_res = bus.left_value ^ bus.right_value;
            4'd5: alu_res = bus.left_value << shamt;
            4'd6: alu_res = bus.left_value >> shamt;
            4'd7: alu_res = $unsigned($signed(bus.left_value) >>> shamt);
            4'd9: alu_res = bus.right_value;
            default: alu_res = '0;
        endcase
    end

    // DONE completes the multiply: the product replaces the ALU result, C/V stay clear.
    assign fin_res = (state == DONE) ? acc : alu_res;
    assign fin_c   = (state == DONE) ? 1'b0 : alu_c;
    assign fin_v   = (state == DONE) ? 1'b0 : alu_v;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            out_valid_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            out_pc_q      <= '0;
            result_q      <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            out_target_q  <= '0;
            flags_q       <= 4'b0000;
        end else begin
            if (mul_start) begin
                mcand  <= bus.left_value;
                mplier <= bus.right_value;
                acc    <= '0;
                count  <= SW'(WIDTH - 1);
            end else if ((state == LATCH) || (state == MUL)) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
            end

            if (bus.flush) begin
                out_valid_q <= 1'b0;
                mem_write_q <= 1'b0;
            end else if (complete) begin
                out_valid_q   <= 1'b1;
                out_pc_q      <= bus.pc;
                out_target_q  <= bus.target_register;
                mem_write_q   <= bus.is_writing_memory;
                mem_address_q <= bus.left_value + bus.adjustment_value;
                mem_data_q    <= bus.right_value;
                if (!bus.is_writing_memory) begin
                    result_q <= fin_res;
                    flags_q  <= {fin_c, fin_res[MSB], fin_v, (fin_res == '0)};
                end
            end else if (!bus.out_hold) begin
                out_valid_q <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid           = out_valid_q;
    assign bus.out_pc              = out_pc_q;
    assign bus.result              = result_q;
    assign bus.out_target_register = out_target_q;
    assign bus.mem_write           = mem_write_q;
    assign bus.mem_address         = mem_address_q;
    assign bus.mem_data            = mem_data_q;
    assign bus.flags               = flags_q;
    assign bus.fb_valid            = out_valid_q && !mem_write_q && (out_target_q != '0);
    assign bus.fb_register         = out_target_q;
    assign bus.fb_value            = result_q;
endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: ALU flags, stores, hold/flush, multiplier timing, async reset.
module tb_execute;
    localparam int W  = 32;
    localparam int RB = 5;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    execute_if #(.WIDTH(W), .REG_BITS(RB)) bus();
    execute #(.WIDTH(W), .REG_BITS(RB)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0] next_pc = 32'h1000;
    logic [31:0] last_pc;

    localparam int NV = 11;
    logic [3:0]  v_op  [NV] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd9, 4'd12, 4'd1, 4'd0};
    logic [31:0] v_l   [NV] = '{32'hF0F0_00FF, 32'h0, 32'h8000_0001, 32'h3, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0010, 32'h0000_AAAA, 32'h5, 32'h1,
                                32'h7FFF_FFFF};
    logic [31:0] v_r   [NV] = '{32'h0FF0_0F0F, 32'h0, 32'h0000_0001, 32'h24, 32'h1F,
                                32'h4, 32'h20, 32'h1234_5678, 32'h6, 32'h2, 32'h1};
    logic [31:0] v_res [NV] = '{32'h00F0_000F, 32'h0, 32'h8000_0000, 32'h30, 32'h1,
                                32'hF800_0000, 32'h8000_0010, 32'h1234_5678, 32'h0,
                                32'hFFFF_FFFF, 32'h8000_0000};
    logic [3:0]  v_flg [NV] = '{4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0100,
                                4'b0100, 4'b0000, 4'b0001, 4'b1100, 4'b0110};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [4:0] tgt);
        bus.in_valid          = 1'b1;
        bus.operation         = op;
        bus.left_value        = l;
        bus.right_value       = r;
        bus.target_register   = tgt;
        bus.adjustment_value  = 32'h0;
        bus.is_writing_memory = 1'b0;
        bus.pc                = next_pc;
        last_pc               = next_pc;
        next_pc               = next_pc + 32'd4;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
        checks++; if (bus.fb_valid !== 1'b0) begin failures++; $display("FAIL reset_fb_valid got=%b exp=0", bus.fb_valid); end
        checks++; if (bus.flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.in_hold !== 1'b0) begin failures++; $display("FAIL reset_in_hold got=%b exp=0", bus.in_hold); end
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        drive(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd1);
        #1;
        checks++; if (bus.in_hold !== 1'b0) begin failures++; $display("FAIL add_in_hold got=%b exp=0", bus.in_hold); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL add_result got=%h exp=0", bus.result); end
        checks++; if (bus.flags !== 4'b1001) begin failures++; $display("FAIL add_flags got=%b exp=1001", bus.flags); end
        checks++; if (bus.out_pc !== last_pc) begin failures++; $display("FAIL add_out_pc got=%h exp=%h", bus.out_pc, last_pc); end
        checks++; if (bus.fb_valid !== 1'b1 || bus.fb_register !== 5'd1 || bus.fb_value !== 32'h0) begin
            failures++; $display("FAIL add_fb got=%b/%0d/%h exp=1/1/0", bus.fb_valid, bus.fb_register, bus.fb_value); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_out_valid_fall got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_sub();
        drive(4'd1, 32'h8000_0000, 32'h1, 5'd0);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.result !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sub_result got=%h exp=7fffffff", bus.result); end
        checks++; if (bus.flags !== 4'b0010) begin failures++; $display("FAIL sub_flags got=%b exp=0010", bus.flags); end
        checks++; if (bus.out_valid !== 1'b1 || bus.fb_valid !== 1'b0) begin
            failures++; $display("FAIL sub_r0_fb got=%b/%b exp=1/0", bus.out_valid, bus.fb_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NV; i++) begin
            drive(v_op[i], v_l[i], v_r[i], 5'(i + 1));
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.result !== v_res[i]) begin
                failures++; $display("FAIL b2b_result[%0d] got=%b/%h exp=1/%h", i, bus.out_valid, bus.result, v_res[i]); end
            checks++; if (bus.flags !== v_flg[i] || bus.out_target_register !== 5'(i + 1)) begin
                failures++; $display("FAIL b2b_flags[%0d] got=%b/%0d exp=%b/%0d", i, bus.flags, bus.out_target_register, v_flg[i], i + 1); end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_store();
        drive(4'd0, 32'h100, 32'hDEAD, 5'd7);
        bus.is_writing_memory = 1'b1;
        bus.adjustment_value  = 32'h10;
        step();
        bus.in_valid          = 1'b0;
        bus.is_writing_memory = 1'b0;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h110 || bus.mem_data !== 32'hDEAD) begin
            failures++; $display("FAIL store_req got=%b/%h/%h exp=1/110/dead", bus.mem_write, bus.mem_address, bus.mem_data); end
        checks++; if (bus.flags !== 4'b0110) begin failures++; $display("FAIL store_flags got=%b exp=0110", bus.flags); end
        checks++; if (bus.fb_valid !== 1'b0) begin failures++; $display("FAIL store_fb_valid got=%b exp=0", bus.fb_valid); end
        step();
        checks++; if (bus.mem_write !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL store_fall got=%b/%b exp=0/0", bus.mem_write, bus.out_valid); end
    endtask

    task automatic test_out_hold();
        drive(4'd0, 32'd10, 32'd20, 5'd6);
        step();
        checks++; if (bus.result !== 32'd30) begin failures++; $display("FAIL hold_pre_result got=%h exp=1e", bus.result); end
        bus.out_hold = 1'b1;
        drive(4'd0, 32'd2, 32'd3, 5'd8);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.in_hold !== 1'b1) begin failures++; $display("FAIL hold_in_hold[%0d] got=%b exp=1", k, bus.in_hold); end
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd30 || bus.out_target_register !== 5'd6) begin
                failures++; $display("FAIL hold_frozen[%0d] got=%b/%h/%0d exp=1/1e/6", k, bus.out_valid, bus.result, bus.out_target_register); end
        end
        bus.out_hold = 1'b0;
        #1;
        checks++; if (bus.in_hold !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", bus.in_hold); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5 || bus.out_target_register !== 5'd8) begin
            failures++; $display("FAIL hold_complete got=%b/%h/%0d exp=1/5/8", bus.out_valid, bus.result, bus.out_target_register); end
        step();
    endtask

    task automatic test_mul(input logic [31:0] l, input logic [31:0] r, input logic [4:0] tgt,
                            input logic [31:0] exp_res, input logic [3:0] exp_flg);
        drive(4'd8, l, r, tgt);
        #1;
        checks++; if (bus.in_hold !== 1'b1) begin failures++; $display("FAIL mul_in_hold[0] got=%b exp=1", bus.in_hold); end
        for (int k = 1; k <= W + 2; k++) begin
            step();
            if (k == W + 2) bus.in_valid = 1'b0;
            #1;
            checks++; if (bus.in_hold !== (k <= W)) begin failures++; $display("FAIL mul_in_hold[%0d] got=%b exp=%b", k, bus.in_hold, (k <= W)); end
            checks++; if (bus.out_valid !== (k == W + 2)) begin failures++; $display("FAIL mul_out_valid[%0d] got=%b exp=%b", k, bus.out_valid, (k == W + 2)); end
        end
        checks++; if (bus.result !== exp_res || bus.flags !== exp_flg) begin
            failures++; $display("FAIL mul_result got=%h/%b exp=%h/%b", bus.result, bus.flags, exp_res, exp_flg); end
        checks++; if (bus.fb_valid !== 1'b1 || bus.fb_register !== tgt || bus.fb_value !== exp_res) begin
            failures++; $display("FAIL mul_fb got=%b/%0d/%h exp=1/%0d/%h", bus.fb_valid, bus.fb_register, bus.fb_value, tgt, exp_res); end
        step();
    endtask

    task automatic test_flush();
        drive(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
        step();
        checks++; if (bus.result !== 32'hFFFF_FFFE || bus.flags !== 4'b1100) begin
            failures++; $display("FAIL flush_pre got=%h/%b exp=fffffffe/1100", bus.result, bus.flags); end
        bus.out_hold = 1'b1;
        drive(4'd8, 32'd7, 32'd9, 5'd10);
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hFFFF_FFFE) begin
                failures++; $display("FAIL flush_frozen[%0d] got=%b/%h exp=1/fffffffe", k, bus.out_valid, bus.result); end
        end
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.in_hold !== 1'b0) begin failures++; $display("FAIL flush_in_hold got=%b exp=0", bus.in_hold); end
        step();
        bus.flush    = 1'b0;
        bus.out_hold = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.mem_write !== 1'b0) begin
            failures++; $display("FAIL flush_outputs got=%b/%b exp=0/0", bus.out_valid, bus.mem_write); end
        checks++; if (bus.flags !== 4'b1100) begin failures++; $display("FAIL flush_flags got=%b exp=1100", bus.flags); end
        drive(4'd0, 32'd2, 32'd3, 5'd11);
        #1;
        checks++; if (bus.in_hold !== 1'b0) begin failures++; $display("FAIL flush_idle_in_hold got=%b exp=0", bus.in_hold); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5 || bus.flags !== 4'b0000) begin
            failures++; $display("FAIL flush_next_add got=%b/%h/%b exp=1/5/0000", bus.out_valid, bus.result, bus.flags); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        drive(4'd1, 32'h1, 32'h2, 5'd12);
        step();
        bus.out_hold = 1'b1;
        drive(4'd8, 32'd5, 32'd5, 5'd13);
        for (int k = 1; k <= 5; k++) step();
        #1;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_hold = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.mem_write !== 1'b0 || bus.fb_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_valids got=%b/%b/%b exp=0/0/0", bus.out_valid, bus.mem_write, bus.fb_valid); end
        checks++; if (bus.result !== 32'h0 || bus.flags !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_regs got=%h/%b exp=0/0000", bus.result, bus.flags); end
        step();
        reset_n = 1'b1;
        drive(4'd0, 32'd2, 32'd3, 5'd14);
        #1;
        checks++; if (bus.in_hold !== 1'b0) begin failures++; $display("FAIL rst_release_in_hold got=%b exp=0", bus.in_hold); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
            failures++; $display("FAIL rst_release_add got=%b/%h exp=1/5", bus.out_valid, bus.result); end
        step();
    endtask

    initial begin
        bus.in_valid          = 1'b0;
        bus.pc                = 32'h0;
        bus.operation         = 4'd0;
        bus.target_register   = 5'd0;
        bus.left_value        = 32'h0;
        bus.right_value       = 32'h0;
        bus.adjustment_value  = 32'h0;
        bus.is_writing_memory = 1'b0;
        bus.flush             = 1'b0;
        bus.out_hold          = 1'b0;
        last_pc               = 32'h0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_store();
        test_out_hold();
        test_mul(32'd7, 32'd6, 5'd3, 32'd42, 4'b0000);
        test_mul(32'hFFFF_FFFF, 32'd3, 5'd4, 32'hFFFF_FFFD, 4'b0100);
        test_mul(32'h0001_0001, 32'h0001_0001, 5'd5, 32'h0002_0001, 4'b0000);
        test_flush();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
